// File: rtl/fast_command_scheduler.sv
// fast_command_scheduler
//
// Arbitrates the 40 MHz fast-command stream. A free-running bunch-crossing counter inserts BCR at
// a programmable orbit position; single-cycle requests (L1A, L1A reset, charge injection,
// waveform-sampler start/stop) are latched into one-deep pending flags and granted one per cycle
// by fixed priority. Every emitted ChargeInj arms a delay counter that later issues an automatic
// L1A on the same code as the external L1A.
//
// Ports:
//   clk40, reset            40 MHz clock, asynchronous active-high reset
//   enable                  low: flags and delay counter clear, only BCR/IDLE emitted
//   bcrPosition             BX at which BCR goes out (>= ORBIT_LEN disables BCR)
//   l1aDelay                ChargeInj-to-auto-L1A distance in BX (0 behaves as 1)
//   req*                    single-cycle request pulses
//   fcValid, fcCode         registered command for the BX on bcCount
//   bcCount                 BX number aligned with fcCode
//   autoL1APending          auto-L1A delay counter running
//   dropCount, slipCount    saturating counters of dropped requests and BCR-slipped auto-L1As

module fast_command_scheduler #(
  parameter int unsigned ORBIT_LEN = 3564
) (
  input  logic        clk40,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] bcrPosition,
  input  logic [8:0]  l1aDelay,
  input  logic        reqL1A,
  input  logic        reqL1ARst,
  input  logic        reqChargeInj,
  input  logic        reqWSStart,
  input  logic        reqWSStop,
  output logic        fcValid,
  output logic [2:0]  fcCode,
  output logic [11:0] bcCount,
  output logic        autoL1APending,
  output logic [7:0]  dropCount,
  output logic [7:0]  slipCount
);

  typedef enum logic [2:0] {
    FcIdle      = 3'd0,
    FcBcr       = 3'd1,
    FcL1A       = 3'd2,
    FcL1ARst    = 3'd3,
    FcChargeInj = 3'd4,
    FcWSStart   = 3'd5,
    FcWSStop    = 3'd6
  } fcCmd_e;

  localparam logic [11:0] LastBc = 12'(ORBIT_LEN - 1);

  // Flag vector bit order: 0 L1A, 1 L1ARst, 2 ChargeInj, 3 WSStart, 4 WSStop.
  logic [4:0]  reqVec;
  logic [4:0]  pendingQ, pendingD;
  logic [4:0]  grant;
  logic [4:0]  dropVec;
  logic [11:0] nextBcQ, nextBcD;
  logic [11:0] bcQ;
  logic [8:0]  delayQ, delayD;
  logic [8:0]  delayLoad;
  logic [7:0]  dropQ, dropD, slipQ, slipD;
  logic [8:0]  dropSum, slipSum;
  logic [2:0]  dropInc;
  fcCmd_e      codeQ, codeD;
  logic        validQ;
  logic        bcrHit, autoDue, autoBusy, autoFire, slipInc;

  assign reqVec    = {reqWSStop, reqWSStart, reqChargeInj, reqL1ARst, reqL1A};
  // nextBcQ is the BX being loaded on the coming edge, so BCR lands exactly on bcrPosition.
  assign bcrHit    = (nextBcQ == bcrPosition);
  assign autoBusy  = (delayQ != 9'd0);
  assign autoDue   = (delayQ == 9'd1);
  assign delayLoad = (l1aDelay == 9'd0) ? 9'd1 : l1aDelay;
  assign nextBcD   = (nextBcQ == LastBc) ? 12'd0 : nextBcQ + 12'd1;

  // Arbitration: BCR, then auto-L1A, then pending flags in fixed order.
  always_comb begin
    codeD    = FcIdle;
    grant    = '0;
    autoFire = 1'b0;
    slipInc  = 1'b0;
    if (bcrHit) begin
      codeD   = FcBcr;
      slipInc = enable & autoDue;
    end else if (enable) begin
      if (autoDue) begin
        codeD    = FcL1A;
        autoFire = 1'b1;
      end else if (pendingQ[0]) begin
        codeD    = FcL1A;
        grant[0] = 1'b1;
      end else if (pendingQ[1]) begin
        codeD    = FcL1ARst;
        grant[1] = 1'b1;
      end else if (pendingQ[2] && !autoBusy) begin
        codeD    = FcChargeInj;
        grant[2] = 1'b1;
      end else if (pendingQ[3]) begin
        codeD    = FcWSStart;
        grant[3] = 1'b1;
      end else if (pendingQ[4]) begin
        codeD    = FcWSStop;
        grant[4] = 1'b1;
      end
    end
  end

  // Flag, delay-counter and statistics next state.
  always_comb begin
    pendingD = '0;
    dropVec  = '0;
    delayD   = '0;
    if (enable) begin
      // A request coinciding with its own grant re-arms the flag instead of being dropped.
      pendingD = (pendingQ & ~grant) | reqVec;
      dropVec  = reqVec & pendingQ & ~grant;
      if (grant[2]) begin
        delayD = delayLoad;
      end else if (autoFire) begin
        delayD = '0;
      end else if (delayQ > 9'd1) begin
        delayD = delayQ - 9'd1;
      end else begin
        // Holds at 1 while BCR keeps the due auto-L1A off the bus.
        delayD = delayQ;
      end
    end
    dropInc = '0;
    for (int i = 0; i < 5; i++) begin
      dropInc = dropInc + {2'b00, dropVec[i]};
    end
    dropSum = {1'b0, dropQ} + {6'd0, dropInc};
    slipSum = {1'b0, slipQ} + {8'd0, slipInc};
    dropD   = dropSum[8] ? 8'hff : dropSum[7:0];
    slipD   = slipSum[8] ? 8'hff : slipSum[7:0];
  end

  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      nextBcQ  <= '0;
      bcQ      <= '0;
      codeQ    <= FcIdle;
      validQ   <= 1'b0;
      pendingQ <= '0;
      delayQ   <= '0;
      dropQ    <= '0;
      slipQ    <= '0;
    end else begin
      nextBcQ  <= nextBcD;
      bcQ      <= nextBcQ;
      codeQ    <= codeD;
      validQ   <= (codeD != FcIdle);
      pendingQ <= pendingD;
      delayQ   <= delayD;
      dropQ    <= dropD;
      slipQ    <= slipD;
    end
  end

  assign fcCode         = codeQ;
  assign fcValid        = validQ;
  assign bcCount        = bcQ;
  assign autoL1APending = autoBusy;
  assign dropCount      = dropQ;
  assign slipCount      = slipQ;

endmodule

// File: tb/tb_fast_command_scheduler.sv
`timescale 1ns / 1ps

module tb_fast_command_scheduler;

  localparam int OrbitLen = 3564;

  logic        clk40 = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] bcrPosition;
  logic [8:0]  l1aDelay;
  logic        reqL1A, reqL1ARst, reqChargeInj, reqWSStart, reqWSStop;
  logic        fcValid;
  logic [2:0]  fcCode;
  logic [11:0] bcCount;
  logic        autoL1APending;
  logic [7:0]  dropCount, slipCount;

  fast_command_scheduler #(
    .ORBIT_LEN(OrbitLen)
  ) dut (
    .clk40         (clk40),
    .reset         (reset),
    .enable        (enable),
    .bcrPosition   (bcrPosition),
    .l1aDelay      (l1aDelay),
    .reqL1A        (reqL1A),
    .reqL1ARst     (reqL1ARst),
    .reqChargeInj  (reqChargeInj),
    .reqWSStart    (reqWSStart),
    .reqWSStop     (reqWSStop),
    .fcValid       (fcValid),
    .fcCode        (fcCode),
    .bcCount       (bcCount),
    .autoL1APending(autoL1APending),
    .dropCount     (dropCount),
    .slipCount     (slipCount)
  );

  always #12 clk40 = ~clk40;

  int nChecks = 0;
  int nFail   = 0;
  bit checkOn = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute edge numbers since reset, the auto-L1A as a due time.
  int       mEdges, mBc, mCode, mAutoAt, mDrop, mSlip;
  bit [4:0] mFlag;
  bit       mAuto;

  task automatic modelStep();
    bit [4:0] req;
    int       nb, win, code;
    bit       due, fire;
    req  = {reqWSStop, reqWSStart, reqChargeInj, reqL1ARst, reqL1A};
    mEdges++;
    nb   = (mEdges - 1) % OrbitLen;
    due  = mAuto && (mEdges >= mAutoAt);
    win  = -1;
    code = 0;
    fire = 0;
    if (nb == int'(bcrPosition)) begin
      code = 1;
      if (enable && due) mSlip = (mSlip < 255) ? mSlip + 1 : 255;
    end else if (enable) begin
      if (due) begin
        code = 2;
        fire = 1;
      end else begin
        for (int i = 0; i < 5; i++)
          if (win < 0 && mFlag[i] && !(i == 2 && mAuto)) win = i;
        if (win >= 0) code = win + 2;
      end
    end
    if (!enable) begin
      mFlag = '0;
      mAuto = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (req[i]) begin
          if (mFlag[i] && win != i) mDrop = (mDrop < 255) ? mDrop + 1 : 255;
          else mFlag[i] = 1;
        end else if (win == i) begin
          mFlag[i] = 0;
        end
      end
      if (fire) mAuto = 0;
      if (win == 2) begin
        mAuto   = 1;
        mAutoAt = mEdges + ((l1aDelay == 0) ? 1 : int'(l1aDelay));
      end
    end
    mBc   = nb;
    mCode = code;
  endtask

  always @(posedge clk40 or posedge reset) begin
    if (reset) begin
      mEdges = 0; mBc = 0; mCode = 0; mAutoAt = 0; mDrop = 0; mSlip = 0;
      mFlag  = '0; mAuto = 0;
    end else begin
      modelStep();
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk40) begin
    if (checkOn) begin
      check("fcCode", int'(fcCode), mCode);
      check("fcValid", int'(fcValid), (mCode != 0) ? 1 : 0);
      check("bcCount", int'(bcCount), mBc);
      check("autoL1APending", int'(autoL1APending), int'(mAuto));
      check("dropCount", int'(dropCount), mDrop);
      check("slipCount", int'(slipCount), mSlip);
    end
  end

  // Event log for the directed scenarios.
  int bcrCnt, l1aCnt, lastBcrBc, lastL1aBc, lastCiBc, pendFirst, pendLast;
  int seq[$];

  task automatic clearMon();
    bcrCnt = 0; l1aCnt = 0; lastBcrBc = -1; lastL1aBc = -1; lastCiBc = -1;
    pendFirst = -1; pendLast = -1;
    seq.delete();
  endtask

  always @(negedge clk40) begin
    if (fcCode != 3'd0) seq.push_back(int'(fcCode));
    if (fcCode == 3'd1) begin bcrCnt++; lastBcrBc = int'(bcCount); end
    if (fcCode == 3'd2) begin l1aCnt++; lastL1aBc = int'(bcCount); end
    if (fcCode == 3'd4) lastCiBc = int'(bcCount);
    if (autoL1APending) begin
      if (pendFirst < 0) pendFirst = int'(bcCount);
      pendLast = int'(bcCount);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk40);
  endtask

  task automatic clearReqs();
    reqL1A = 0; reqL1ARst = 0; reqChargeInj = 0; reqWSStart = 0; reqWSStop = 0;
  endtask

  // Asynchronous reset mid-cycle; returns on the negedge where reset is released,
  // so the next posedge loads bcCount=0.
  task automatic doReset();
    @(posedge clk40);
    #3 reset = 1;
    clearReqs();
    repeat (2) @(negedge clk40);
    reset = 0;
  endtask

  int density;

  initial begin
    reset = 0; enable = 1; bcrPosition = 12'd0; l1aDelay = 9'd1;
    clearReqs();
    clearMon();
    #1 reset = 1;
    #1 checkOn = 1;
    repeat (2) @(negedge clk40);
    reset = 0;

    // Idle orbits: BCR only at BX 0.
    doReset();
    enable = 1; bcrPosition = 12'd0;
    clearMon();
    cycles(2 * OrbitLen);
    #1;
    check("idle_bcr_count", bcrCnt, 2);
    check("idle_bcr_bx", lastBcrBc, 0);
    check("idle_other_cmds", seq.size(), 2);
    check("idle_drop", int'(dropCount), 0);

    // ChargeInj at 101, auto-L1A 11 BX later.
    doReset();
    bcrPosition = 12'd4000; l1aDelay = 9'd11;
    clearMon();
    cycles(100); reqChargeInj = 1; cycles(1); reqChargeInj = 0;
    cycles(20);
    #1;
    check("ci_bx", lastCiBc, 101);
    check("auto_l1a_bx", lastL1aBc, 112);
    check("auto_l1a_count", l1aCnt, 1);
    check("pend_first", pendFirst, 101);
    check("pend_last", pendLast, 111);
    check("no_slip", int'(slipCount), 0);

    // Same with BCR on the auto-L1A slot.
    doReset();
    bcrPosition = 12'd112; l1aDelay = 9'd11;
    clearMon();
    cycles(100); reqChargeInj = 1; cycles(1); reqChargeInj = 0;
    cycles(20);
    #1;
    check("slip_bcr_bx", lastBcrBc, 112);
    check("slip_l1a_bx", lastL1aBc, 113);
    check("slip_count", int'(slipCount), 1);
    check("slip_pend_last", pendLast, 112);
    check("model_slip", mSlip, 1);

    // Three simultaneous requests go out in priority order.
    doReset();
    bcrPosition = 12'd4000;
    cycles(200);
    clearMon();
    reqL1A = 1; reqL1ARst = 1; reqWSStart = 1; cycles(1); clearReqs();
    cycles(6);
    #1;
    check("order_len", seq.size(), 3);
    if (seq.size() == 3) begin
      check("order_0", seq[0], 2);
      check("order_1", seq[1], 3);
      check("order_2", seq[2], 5);
    end
    check("order_drop", int'(dropCount), 0);

    // Duplicate L1A while BCR holds the slot.
    doReset();
    bcrPosition = 12'd50;
    clearMon();
    cycles(49); reqL1A = 1; cycles(2); reqL1A = 0;
    cycles(5);
    #1;
    check("dup_l1a_count", l1aCnt, 1);
    check("dup_l1a_bx", lastL1aBc, 51);
    check("dup_drop", int'(dropCount), 1);
    // WSStop starved by a continuous L1A stream: every repeat is dropped.
    reqL1A = 1; reqWSStop = 1; cycles(300); clearReqs();
    cycles(3);
    #1;
    check("drop_saturate", int'(dropCount), 255);
    check("model_drop", mDrop, 255);

    // Enable drop cancels the auto-L1A; async reset clears everything.
    doReset();
    bcrPosition = 12'd4000; l1aDelay = 9'd20;
    clearMon();
    cycles(10); reqChargeInj = 1; cycles(1); reqChargeInj = 0;
    cycles(5); enable = 0; cycles(3); enable = 1;
    cycles(40);
    #1;
    check("cancel_ci_bx", lastCiBc, 11);
    check("cancel_no_l1a", l1aCnt, 0);
    check("cancel_pending", int'(autoL1APending), 0);
    @(negedge clk40);
    reqWSStart = 1;
    @(posedge clk40);
    #3 reset = 1;
    #1;
    check("rst_fcCode", int'(fcCode), 0);
    check("rst_fcValid", int'(fcValid), 0);
    check("rst_bcCount", int'(bcCount), 0);
    check("rst_pending", int'(autoL1APending), 0);
    check("rst_drop", int'(dropCount), 0);
    check("rst_slip", int'(slipCount), 0);
    clearReqs();
    repeat (2) @(negedge clk40);
    reset = 0;

    // Randomized traffic against the model.
    density = 10;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk40);
      if (i % 40 == 0) begin
        if ($urandom_range(0, 3) == 0) bcrPosition = 12'($urandom_range(3564, 4095));
        else bcrPosition = 12'((mBc + int'($urandom_range(2, 30))) % OrbitLen);
        l1aDelay = ($urandom_range(0, 4) == 0) ? 9'd0 : 9'($urandom_range(1, 25));
        density  = int'($urandom_range(2, 40));
      end
      enable       = ($urandom_range(0, 99) >= 3);
      reqL1A       = (int'($urandom_range(0, 99)) < density);
      reqL1ARst    = (int'($urandom_range(0, 99)) < density);
      reqChargeInj = (int'($urandom_range(0, 99)) < density);
      reqWSStart   = (int'($urandom_range(0, 99)) < density);
      reqWSStop    = (int'($urandom_range(0, 99)) < density);
      if (i == 4000) begin
        @(posedge clk40);
        #3 reset = 1;
        @(negedge clk40);
        reset = 0;
      end
    end
    clearReqs();
    enable = 1;
    cycles(5);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
